round_key_store: RTL and testbench
==================================

Name: round_key_store

Overview:
- Parametrised round-key buffer between the byte-serial key expansion datapath and the encryption/decryption round engine.
- Captures each expanded round key as it streams out of key expansion and packs it into one of NUM_KEYS slots.
- Replays any stored round key on demand over a valid/ready stream of BUS_BYTES bytes per beat.
- Supports forward (encrypt) and reversed (decrypt) round indexing, and lets round 0 be read while later rounds are still being expanded.

Parameters:
- KEY_W, 128, round key width in bits; multiple of 8*BUS_BYTES.
- BUS_BYTES, 1, bytes per beat on both the capture and replay buses (1, 2, 4, 8 or 16).
- NUM_KEYS, 11, number of round-key slots (11/13/15 for AES-128/192/256).
- IDX_W, 4, width of round index; must satisfy 2^IDX_W >= NUM_KEYS.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart for a new cipher key; same effect as rst except slot contents are kept.
- in_valid  in  1  capture beat present; there is no back-pressure.
- in_data  in  8*BUS_BYTES  capture beat; first beat of a key is its most significant bytes.
- rd_req  in  1  replay request.
- rd_round  in  IDX_W  round number requested.
- rd_reverse  in  1  1 = decrypt order: slot = NUM_KEYS-1-rd_round.
- rd_ready  out  1  replay request can be accepted this cycle.
- rd_err  out  1  one-cycle pulse: request rejected.
- out_valid  out  1  replay beat valid.
- out_data  out  8*BUS_BYTES  replay beat, most significant bytes first.
- out_last  out  1  final beat of the current key.
- out_ready  in  1  consumer accepts the beat.
- stored_count  out  IDX_W  number of complete keys captured.
- keys_full  out  1  stored_count == NUM_KEYS.
- overflow  out  1  sticky: in_valid seen while keys_full.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: rd_ready=1, rd_err=0, out_valid=0, out_data=0, out_last=0, stored_count=0, keys_full=0, overflow=0. Slot memory is not reset.
- Capture side:
  - BEATS = KEY_W/(8*BUS_BYTES).
  - Each in_valid shifts in_data into a KEY_W packing register (shift left by 8*BUS_BYTES, new beat in the LSBs) and increments beat_cnt.
  - On beat BEATS-1 the completed key, including the current beat, is written to slot stored_count. beat_cnt wraps to 0 and stored_count increments on the same edge.
  - While keys_full, in_valid is ignored (no write, no count change) and overflow sets. overflow clears only on rst or clear.
  - in_valid low holds the partial key; gaps between beats are allowed.
- Replay FSM, states IDLE and STREAM:
  - IDLE: rd_ready=1. Request accepted on rd_req & rd_ready.
  - Mapped slot s = rd_reverse ? NUM_KEYS-1-rd_round : rd_round.
  - If rd_round >= NUM_KEYS or s >= stored_count (registered value): rd_err=1 for the next cycle and the FSM stays in IDLE.
  - Otherwise load slot s into the replay shift register, go to STREAM, and raise out_valid on the next cycle (1-cycle latency).
  - STREAM: rd_ready=0; out_data = top 8*BUS_BYTES bits of the shift register. On out_valid & out_ready the register shifts and the beat counter increments.
  - out_last=1 on beat BEATS-1. When that beat is accepted: out_valid=0, return to IDLE, rd_ready=1 in the following cycle.
  - out_valid with out_ready low holds out_data stable (AXI-stream rules).
- Simultaneous events:
  - A key completing on the same edge as a request for that slot is not yet visible; the request gets rd_err. No bypass.
  - Capture and replay are fully concurrent. A slot being replayed is never overwritten unless clear has been issued.
- clear or rst mid-stream: next cycle out_valid=0, out_last=0, FSM to IDLE, beat_cnt=0, stored_count=0.
- rd_req while in STREAM is ignored (rd_ready=0); no rd_err is raised.

Decomposition:
- Shared package aes_pkg:
  - constants AES_BLOCK_W=128, NR_128=10, NR_192=12, NR_256=14;
  - replay FSM state encoding IDLE/STREAM;
  - function key_beats(KEY_W, BUS_BYTES).
- One natural sub-module: key_slot_ram (NUM_KEYS x KEY_W, 1 write port, 1 asynchronous read port), so the storage can later be mapped to a BRAM.

Test Plan:
- rst, then capture FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c followed by its 10 expansions, BUS_BYTES=1 (176 beats) -> stored_count 11, keys_full=1; replay round 10 -> 16 beats d0 14 f9 … a6, out_last only on the 16th.
- After one key is captured, rd_round=1 -> rd_err pulse, no out_valid. rd_round=0 -> out_valid the cycle after acceptance, data 2b…3c.
- rd_reverse=1, rd_round=0 with all keys stored -> returns round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
- out_ready toggled 1,0,0,1 during replay -> out_data held stable while stalled; exactly 16 accepted beats.
- 177th in_valid after full -> overflow=1, slot 10 unchanged. clear asserted mid-stream -> out_valid=0 next cycle, stored_count=0, overflow=0.
- BUS_BYTES=4 build, same key -> 4 beats per key; round-1 key a0fafe17 88542cb1 23a33939 2a6c7605 returned in that order.

Source files
------------

// File: rtl/round_key_store_pkg.sv
// Shared AES constants, replay FSM encoding and beat-count helper for the round-key store.
package round_key_store_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned NR_128      = 10;
    localparam int unsigned NR_192      = 12;
    localparam int unsigned NR_256      = 14;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    function automatic int unsigned key_beats(input int unsigned key_w,
                                              input int unsigned bus_bytes);
        return key_w / (8 * bus_bytes);
    endfunction

endpackage

// File: rtl/round_key_store_if.sv
// Capture, replay-request and replay-stream signals between key expansion, store and round engine.
interface round_key_store_if #(
    parameter int unsigned BUS_BYTES = 1,
    parameter int unsigned IDX_W     = 4
);

    logic                   in_valid;
    logic [8*BUS_BYTES-1:0] in_data;
    logic                   rd_req;
    logic [IDX_W-1:0]       rd_round;
    logic                   rd_reverse;
    logic                   rd_ready;
    logic                   rd_err;
    logic                   out_valid;
    logic [8*BUS_BYTES-1:0] out_data;
    logic                   out_last;
    logic                   out_ready;

    modport master (
        output in_valid, in_data, rd_req, rd_round, rd_reverse, out_ready,
        input  rd_ready, rd_err, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, rd_req, rd_round, rd_reverse, out_ready,
        output rd_ready, rd_err, out_valid, out_data, out_last
    );

endinterface

// File: rtl/round_key_store_key_slot_ram.sv
// Round-key slot storage: one synchronous write port, one asynchronous read port.
module round_key_store_key_slot_ram #(
    parameter int unsigned NUM_KEYS = 11,
    parameter int unsigned KEY_W    = 128,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [KEY_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [KEY_W-1:0]  rdata
);

    logic [KEY_W-1:0] mem [NUM_KEYS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/round_key_store.sv
// Packs byte-serial expanded round keys into slots and replays any stored key as a beat stream.
module round_key_store
    import round_key_store_pkg::*;
#(
    parameter int unsigned KEY_W     = 128,
    parameter int unsigned BUS_BYTES = 1,
    parameter int unsigned NUM_KEYS  = 11,
    parameter int unsigned IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    round_key_store_if.slave bus,
    output logic [IDX_W-1:0] stored_count,
    output logic             keys_full,
    output logic             overflow
);

    localparam int unsigned      BW         = 8 * BUS_BYTES;
    localparam int unsigned      BEATS      = key_beats(KEY_W, BUS_BYTES);
    localparam int unsigned      CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [IDX_W:0]   NUM_KEYS_W = (IDX_W + 1)'(NUM_KEYS);

    // Capture side
    logic [KEY_W-1:0] pack_q;
    logic [KEY_W-1:0] pack_shift;
    logic [CNT_W-1:0] cap_cnt_q;
    logic [IDX_W-1:0] count_q;
    logic             overflow_q;
    logic             full;
    logic             cap_last;
    logic             wr_en;

    assign full       = ({1'b0, count_q} == NUM_KEYS_W);
    assign cap_last   = (cap_cnt_q == LAST_BEAT);
    assign pack_shift = KEY_W'({pack_q, bus.in_data});
    assign wr_en      = bus.in_valid && !full && cap_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pack_q     <= '0;
            cap_cnt_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.in_valid) begin
            if (full) begin
                overflow_q <= 1'b1;
            end else begin
                pack_q <= pack_shift;
                if (cap_last) begin
                    cap_cnt_q <= '0;
                    count_q   <= count_q + IDX_W'(1);
                end else begin
                    cap_cnt_q <= cap_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Replay side
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [KEY_W-1:0] sh_q;
    logic [KEY_W-1:0] slot_data;
    logic [CNT_W-1:0] out_cnt_q;
    logic             rd_err_q;
    logic [IDX_W-1:0] slot;
    logic             req_bad;
    logic             accept;
    logic             load;
    logic             beat_ok;
    logic             last_beat;

    assign slot      = bus.rd_reverse ? IDX_W'(NUM_KEYS - 1) - bus.rd_round : bus.rd_round;
    // Compares against the registered count, so a key finishing this edge is not yet readable.
    assign req_bad   = ({1'b0, bus.rd_round} >= NUM_KEYS_W) || (slot >= count_q);
    assign accept    = bus.rd_req && (state_q == ST_IDLE);
    assign load      = accept && !req_bad;
    assign beat_ok   = (state_q == ST_STREAM) && bus.out_ready;
    assign last_beat = (state_q == ST_STREAM) && (out_cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load) state_d = ST_STREAM;
            ST_STREAM: if (beat_ok && last_beat) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            out_cnt_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_err_q <= accept && req_bad;
            if (load) begin
                sh_q      <= slot_data;
                out_cnt_q <= '0;
            end else if (beat_ok) begin
                sh_q      <= sh_q << BW;
                out_cnt_q <= last_beat ? '0 : out_cnt_q + CNT_W'(1);
            end
        end
    end

    round_key_store_key_slot_ram #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W),
        .ADDR_W   (IDX_W)
    ) u_slot_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count_q),
        .wdata (pack_shift),
        .raddr (slot),
        .rdata (slot_data)
    );

    assign bus.rd_ready  = (state_q == ST_IDLE);
    assign bus.rd_err    = rd_err_q;
    assign bus.out_valid = (state_q == ST_STREAM);
    assign bus.out_data  = sh_q[KEY_W-1 -: BW];
    assign bus.out_last  = last_beat;
    assign stored_count  = count_q;
    assign keys_full     = full;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: 1-byte and 4-byte bus builds fed the FIPS-197 AES-128 schedule.
module tb_round_key_store;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic clear4;

    always #5 clk = ~clk;

    round_key_store_if #(.BUS_BYTES(1), .IDX_W(4)) b1 ();
    round_key_store_if #(.BUS_BYTES(4), .IDX_W(4)) b4 ();

    logic [3:0] cnt1;
    logic [3:0] cnt4;
    logic       full1;
    logic       full4;
    logic       ovf1;
    logic       ovf4;

    round_key_store #(.KEY_W(128), .BUS_BYTES(1), .NUM_KEYS(11), .IDX_W(4)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .bus          (b1),
        .stored_count (cnt1),
        .keys_full    (full1),
        .overflow     (ovf1)
    );

    round_key_store #(.KEY_W(128), .BUS_BYTES(4), .NUM_KEYS(11), .IDX_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear4),
        .bus          (b4),
        .stored_count (cnt4),
        .keys_full    (full4),
        .overflow     (ovf4)
    );

    int checks = 0;
    int errors = 0;
    logic [127:0] keys [11];

    typedef struct {
        logic [3:0] round;
        logic       rev;
        logic       exp_err;
        int         exp_idx;
        logic [3:0] ready_pat;
        string      name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cap_beats(input logic [127:0] k, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            b1.in_valid = 1'b1;
            b1.in_data  = k[127-8*i -: 8];
            @(negedge clk);
        end
        b1.in_valid = 1'b0;
    endtask

    // Issues one request; on acceptance drains the stream with out_ready following pat.
    task automatic read_key(input logic [3:0] round, input logic rev, input logic [3:0] pat,
                            output logic err, output logic [127:0] got, output int beats);
        logic [7:0] prev_data;
        logic       prev_stall;
        err        = 1'b0;
        got        = '0;
        beats      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        b1.rd_req     = 1'b1;
        b1.rd_round   = round;
        b1.rd_reverse = rev;
        @(negedge clk);
        b1.rd_req = 1'b0;
        err = b1.rd_err;
        if (err) return;
        check("latency_valid", 128'(b1.out_valid), 128'd1);
        for (int cyc = 0; cyc < 200 && beats < 16; cyc++) begin
            b1.out_ready = pat[2'(cyc)];
            if (prev_stall) check("stall_hold", 128'(b1.out_data), 128'(prev_data));
            if (b1.out_valid && b1.out_ready) begin
                check("out_last", 128'(b1.out_last), 128'(beats == 15));
                got = {got[119:0], b1.out_data};
                beats++;
            end
            prev_stall = b1.out_valid && !b1.out_ready;
            prev_data  = b1.out_data;
            @(negedge clk);
        end
        b1.out_ready = 1'b0;
        check("idle_after_last", 128'({b1.out_valid, b1.rd_ready}), 128'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         err;
        logic [127:0] got;
        int           beats;

        keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{4'd10, 1'b0, 1'b0, 10, 4'hF, "fwd_r10"};
        vecs[1] = '{4'd0,  1'b1, 1'b0, 10, 4'hF, "rev_r0"};
        vecs[2] = '{4'd3,  1'b0, 1'b0, 3,  4'hF, "fwd_r3"};
        vecs[3] = '{4'd3,  1'b1, 1'b0, 7,  4'hF, "rev_r3"};
        vecs[4] = '{4'd10, 1'b1, 1'b0, 0,  4'hF, "rev_r10"};
        vecs[5] = '{4'd11, 1'b0, 1'b1, 0,  4'hF, "fwd_r11_bad"};
        vecs[6] = '{4'd15, 1'b1, 1'b1, 0,  4'hF, "rev_r15_bad"};
        vecs[7] = '{4'd5,  1'b0, 1'b0, 5,  4'b1001, "stall_r5"};

        rst = 1'b1; clear = 1'b0; clear4 = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.rd_req = 1'b0; b1.rd_round = '0;
        b1.rd_reverse = 1'b0; b1.out_ready = 1'b0;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.rd_req = 1'b0; b4.rd_round = '0;
        b4.rd_reverse = 1'b0; b4.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state: {rd_ready, rd_err, out_valid, out_last, keys_full, overflow, count, data}
        check("reset_bus1", 128'({b1.rd_ready, b1.rd_err, b1.out_valid, b1.out_last,
                                  full1, ovf1, cnt1, b1.out_data}),
              128'({6'b100000, 4'd0, 8'd0}));
        check("reset_bus4", 128'({b4.rd_ready, b4.rd_err, b4.out_valid, b4.out_last,
                                  full4, ovf4, cnt4, b4.out_data}),
              128'({6'b100000, 4'd0, 32'd0}));

        // One key captured: round 1 rejected, round 0 readable.
        cap_beats(keys[0], 0, 15);
        check("count_after_one", 128'(cnt1), 128'd1);
        read_key(4'd1, 1'b0, 4'hF, err, got, beats);
        check("early_r1_err", 128'(err), 128'd1);
        check("early_r1_no_valid", 128'(b1.out_valid), 128'd0);
        @(negedge clk);
        check("rd_err_one_cycle", 128'(b1.rd_err), 128'd0);
        read_key(4'd1, 1'b1, 4'hF, err, got, beats);
        check("early_rev_r1_err", 128'(err), 128'd1);
        @(negedge clk);
        read_key(4'd0, 1'b0, 4'hF, err, got, beats);
        check("early_r0_err", 128'(err), 128'd0);
        check("early_r0_data", got, keys[0]);
        check("early_r0_beats", 128'(beats), 128'd16);

        // Request for slot 1 on the same edge its final beat lands: no bypass.
        cap_beats(keys[1], 0, 14);
        b1.in_valid = 1'b1; b1.in_data = keys[1][7:0];
        b1.rd_req = 1'b1; b1.rd_round = 4'd1; b1.rd_reverse = 1'b0;
        @(negedge clk);
        b1.in_valid = 1'b0; b1.rd_req = 1'b0;
        check("same_edge_err", 128'(b1.rd_err), 128'd1);
        check("same_edge_count", 128'(cnt1), 128'd2);
        check("same_edge_no_valid", 128'(b1.out_valid), 128'd0);

        for (int k = 2; k < 11; k++) cap_beats(keys[k], 0, 15);
        check("full_status", 128'({cnt1, full1, ovf1}), 128'({4'd11, 1'b1, 1'b0}));

        for (int i = 0; i < 8; i++) begin
            read_key(vecs[i].round, vecs[i].rev, vecs[i].ready_pat, err, got, beats);
            check({vecs[i].name, "_err"}, 128'(err), 128'(vecs[i].exp_err));
            if (!vecs[i].exp_err) begin
                check({vecs[i].name, "_data"}, got, keys[vecs[i].exp_idx]);
                check({vecs[i].name, "_beats"}, 128'(beats), 128'd16);
            end else begin
                check({vecs[i].name, "_no_valid"}, 128'(b1.out_valid), 128'd0);
                @(negedge clk);
            end
        end

        // Beat beyond full: flagged, no count change, slot 10 intact.
        cap_beats(128'hffffffffffffffffffffffffffffffff, 0, 0);
        check("overflow_status", 128'({cnt1, full1, ovf1}), 128'({4'd11, 1'b1, 1'b1}));
        read_key(4'd10, 1'b0, 4'hF, err, got, beats);
        check("overflow_r10_data", got, keys[10]);

        // clear while a stream is stalled mid-key.
        b1.rd_req = 1'b1; b1.rd_round = 4'd2; b1.rd_reverse = 1'b0; b1.out_ready = 1'b0;
        @(negedge clk);
        b1.rd_req = 1'b0;
        check("pre_clear_beat", 128'({b1.out_valid, b1.out_data}), 128'({1'b1, keys[2][127:120]}));
        b1.out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        b1.out_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check("post_clear", 128'({b1.out_valid, b1.out_last, b1.rd_ready, cnt1, full1, ovf1}),
              128'({3'b001, 4'd0, 1'b0, 1'b0}));
        read_key(4'd0, 1'b0, 4'hF, err, got, beats);
        check("post_clear_r0_err", 128'(err), 128'd1);
        @(negedge clk);

        // 4-byte build: two keys, then round 1 in word order.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                b4.in_valid = 1'b1;
                b4.in_data  = keys[k][127-32*i -: 32];
                @(negedge clk);
            end
        end
        b4.in_valid = 1'b0;
        check("bus4_count", 128'(cnt4), 128'd2);
        b4.rd_req = 1'b1; b4.rd_round = 4'd1; b4.rd_reverse = 1'b0;
        @(negedge clk);
        b4.rd_req = 1'b0;
        b4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bus4_beat%0d", i),
                  128'({b4.out_valid, b4.out_last, b4.out_data}),
                  128'({1'b1, i == 3, keys[1][127-32*i -: 32]}));
            @(negedge clk);
        end
        b4.out_ready = 1'b0;
        check("bus4_idle", 128'({b4.out_valid, b4.rd_ready}), 128'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
